avmm_timer_bank: RTL and testbench

- Parametrised Avalon-MM slave holding N_CH independent down-counting timers with per-channel control, reload and sticky expiry status.
- Successor to the fixed single-instance bus-slave wrapper: same s0-style word-addressed read/write port and reset synchroniser, generalised in channel count and counter width.
- Sits directly on the system Avalon-MM interconnect as a peripheral.

---
 rtl/avmm_timer_bank.sv | 174 +++++++++++++++++
 tb/tb_avmm_timer_bank.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_timer_bank.sv
// Avalon-MM slave with N_CH down-counting timers: per-channel CTRL/LOAD/COUNT/STATUS at word offsets 0..3.
// Defining AVMM_TIMER_IRQ_EN adds a registered irq output (OR of EXP & IE over all channels).
module avmm_timer_bank #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] address,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic              read,
  output logic [31:0]       readdata,
  output logic              readdatavalid
`ifdef AVMM_TIMER_IRQ_EN
  ,
  output logic              irq
`endif
);

  // Reset asserts asynchronously and releases two clock edges after rst_in rises.
  logic sync0_q;
  logic sync1_q;
  logic rst_n;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= 1'b1;
      sync1_q <= sync0_q;
    end
  end

  assign rst_n = sync1_q;

  logic [1:0]          offset;
  logic [ADDR_W-3:0]   chan_addr;
  logic [N_CH-1:0]     ch_sel;
  logic [N_CH*32-1:0]  rd_flat;
  logic [31:0]         rd_mux;
  logic [31:0]         readdata_q;
  logic                rvalid_q;
`ifdef AVMM_TIMER_IRQ_EN
  logic [N_CH-1:0]     exp_vec;
  logic [N_CH-1:0]     ie_vec;
  logic                irq_q;
`endif

  assign offset    = address[1:0];
  assign chan_addr = address[ADDR_W-1:2];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    localparam logic [ADDR_W-3:0] CH_IDX = (ADDR_W-2)'(gi);

    logic             en_q, en_d;
    logic             rl_q, rl_d;
    logic             ie_q, ie_d;
    logic             exp_q, exp_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             at_zero;
    logic             expire;
    logic [31:0]      rd_word;

    assign ch_sel[gi] = (chan_addr == CH_IDX);
    assign at_zero    = (count_q == '0);
    assign expire     = en_q & at_zero;

    // Tick first, then let a same-cycle bus write override it; expiry always wins over W1C.
    always_comb begin
      en_d    = en_q;
      rl_d    = rl_q;
      ie_d    = ie_q;
      load_d  = load_q;
      count_d = count_q;
      exp_d   = exp_q | expire;
      if (en_q) begin
        if (!at_zero) begin
          count_d = count_q - 1'b1;
        end else if (rl_q) begin
          count_d = load_q;
        end else begin
          en_d = 1'b0;
        end
      end
      if (write && ch_sel[gi]) begin
        case (offset)
          2'd0: begin
            en_d = writedata[0];
            rl_d = writedata[1];
            ie_d = writedata[2];
          end
          2'd1:    load_d  = writedata[CNT_W-1:0];
          2'd2:    count_d = writedata[CNT_W-1:0];
          default: if (writedata[0]) exp_d = expire;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        en_q    <= 1'b0;
        rl_q    <= 1'b0;
        ie_q    <= 1'b0;
        exp_q   <= 1'b0;
        load_q  <= '0;
        count_q <= '0;
      end else begin
        en_q    <= en_d;
        rl_q    <= rl_d;
        ie_q    <= ie_d;
        exp_q   <= exp_d;
        load_q  <= load_d;
        count_q <= count_d;
      end
    end

    always_comb begin
      rd_word = '0;
      case (offset)
        2'd0:    rd_word = {29'd0, ie_q, rl_q, en_q};
        2'd1:    rd_word = 32'(load_q);
        2'd2:    rd_word = 32'(count_q);
        default: rd_word = {31'd0, exp_q};
      endcase
    end

    assign rd_flat[gi*32 +: 32] = ch_sel[gi] ? rd_word : 32'd0;

`ifdef AVMM_TIMER_IRQ_EN
    assign exp_vec[gi] = exp_q;
    assign ie_vec[gi]  = ie_q;
`endif
  end

  // Addresses beyond the last channel select nothing and read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CH; i++) begin
      rd_mux = rd_mux | rd_flat[i*32 +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      rvalid_q <= read;
      if (read) begin
        readdata_q <= rd_mux;
      end
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;

`ifdef AVMM_TIMER_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(exp_vec & ie_vec);
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_avmm_timer_bank.sv
// Bench for avmm_timer_bank: directed table, hand-written collision/reset/irq sequences, random traffic vs. a reference model.
`timescale 1ns/1ps
module tb_avmm_timer_bank;
  localparam int N_CH   = 4;
  localparam int CNT_W  = 32;
  localparam int ADDR_W = 8;
  localparam int N_ADDR = 4 * N_CH;
  localparam logic [31:0] MASK = (CNT_W == 32) ? 32'hFFFF_FFFF : 32'((64'd1 << CNT_W) - 64'd1);

  logic              clk = 1'b0;
  logic              rst_in = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              write = 1'b0;
  logic [31:0]       writedata = '0;
  logic              read = 1'b0;
  logic [31:0]       readdata;
  logic              readdatavalid;
`ifdef AVMM_TIMER_IRQ_EN
  logic              irq;
`endif

  avmm_timer_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .address       (address),
    .write         (write),
    .writedata     (writedata),
    .read          (read),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
`ifdef AVMM_TIMER_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_irq(string name, bit exp);
`ifdef AVMM_TIMER_IRQ_EN
    chk(name, 32'(irq), 32'(exp));
`endif
  endtask

  // Reference model: timer state as plain arrays, updated once per clock from the register rules.
  logic [31:0] m_load [N_CH];
  logic [31:0] m_count[N_CH];
  bit          m_en [N_CH];
  bit          m_rl [N_CH];
  bit          m_ie [N_CH];
  bit          m_exp[N_CH];
  logic [31:0] m_rdata;
  bit          m_rvalid;
  bit          m_irq;

  function automatic void m_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_load[c] = 0; m_count[c] = 0;
      m_en[c] = 0; m_rl[c] = 0; m_ie[c] = 0; m_exp[c] = 0;
    end
    m_rdata = 0; m_rvalid = 0; m_irq = 0;
  endfunction

  function automatic logic [31:0] m_read(int a);
    int c;
    if (a >= N_ADDR) return 32'd0;
    c = a / 4;
    case (a % 4)
      0:       return 32'(m_en[c]) + 32'(m_rl[c]) * 2 + 32'(m_ie[c]) * 4;
      1:       return m_load[c];
      2:       return m_count[c];
      default: return 32'(m_exp[c]);
    endcase
  endfunction

  function automatic void m_step(int a, bit wr, logic [31:0] wd, bit rd);
    logic [31:0] rv;
    bit irq_n;
    rv = m_read(a);
    irq_n = 0;
    for (int c = 0; c < N_CH; c++) if (m_exp[c] && m_ie[c]) irq_n = 1;
    for (int c = 0; c < N_CH; c++) begin
      bit hit;
      bit expiring;
      hit = wr && (a < N_ADDR) && (a / 4 == c);
      expiring = m_en[c] && (m_count[c] == 0);
      if (m_en[c]) begin
        if (m_count[c] != 0) m_count[c] = m_count[c] - 1;
        else begin
          m_exp[c] = 1;
          if (m_rl[c]) m_count[c] = m_load[c];
          else m_en[c] = 0;
        end
      end
      if (hit) begin
        case (a % 4)
          0: begin m_en[c] = wd[0]; m_rl[c] = wd[1]; m_ie[c] = wd[2]; end
          1: m_load[c] = wd & MASK;
          2: m_count[c] = wd & MASK;
          default: if (wd[0] && !expiring) m_exp[c] = 0;
        endcase
      end
    end
    m_rvalid = rd;
    if (rd) m_rdata = rv;
    m_irq = irq_n;
  endfunction

  // One bus cycle: drive at negedge, advance the model at posedge, compare just after.
  task automatic cycle(int a, bit wr, logic [31:0] wd, bit rd);
    @(negedge clk);
    address = ADDR_W'(a); write = wr; writedata = wd; read = rd;
    @(posedge clk);
    m_step(a, wr, wd, rd);
    #1;
    write = 1'b0; read = 1'b0;
    chk("model_rdvalid", 32'(readdatavalid), 32'(m_rvalid));
    chk("model_rdata", readdata, m_rdata);
    chk_irq("model_irq", m_irq);
    $display("txn a=0x%02h wr=%0d wd=0x%08h rd=%0d -> rdv=%0d rdata=0x%08h",
             a, wr, wd, rd, readdatavalid, readdata);
  endtask

  typedef struct {
    int          addr;
    bit          wr;
    logic [31:0] wd;
    bit          rd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int a, bit wr, logic [31:0] wd, bit rd, logic [31:0] exp);
    vec_t v;
    v.addr = a; v.wr = wr; v.wd = wd; v.rd = rd; v.exp = exp;
    tbl.push_back(v);
  endfunction

  initial begin
    // One-shot on channel 0.
    add(1, 1, 5, 0, 0);  add(2, 1, 5, 0, 0);  add(0, 1, 1, 0, 0);
    add(2, 0, 0, 1, 5);  add(2, 0, 0, 1, 4);  add(2, 0, 0, 1, 3);
    add(2, 0, 0, 1, 2);  add(2, 0, 0, 1, 1);  add(2, 0, 0, 1, 0);
    add(3, 0, 0, 1, 1);  add(0, 0, 0, 1, 0);  add(2, 0, 0, 1, 0);
    add(1, 0, 0, 1, 5);  add(3, 1, 1, 0, 0);  add(3, 0, 0, 1, 0);
    // Auto-reload on channel 2, period LOAD+1.
    add(9, 1, 3, 0, 0);  add(10, 1, 3, 0, 0); add(8, 1, 3, 0, 0);
    add(10, 0, 0, 1, 3); add(10, 0, 0, 1, 2); add(10, 0, 0, 1, 1);
    add(10, 0, 0, 1, 0); add(10, 0, 0, 1, 3); add(11, 0, 0, 1, 1);
    add(11, 1, 1, 0, 0); add(11, 0, 0, 1, 0); add(11, 0, 0, 1, 1);
    add(8, 1, 0, 0, 0);  add(11, 1, 1, 0, 0); add(11, 0, 0, 1, 0);
    // Out-of-range accesses, back-to-back reads, read+write together.
    add(16, 1, 32'hFFFF_FFFF, 0, 0); add(16, 0, 0, 1, 0); add(255, 0, 0, 1, 0);
    add(1, 0, 0, 1, 5);  add(9, 0, 0, 1, 3);  add(0, 0, 0, 1, 0);
    add(5, 1, 32'h1234, 0, 0);
    add(1, 0, 0, 1, 5);  add(5, 0, 0, 1, 32'h1234); add(9, 0, 0, 1, 3);
    add(5, 1, 32'h77, 1, 32'h1234); add(5, 0, 0, 1, 32'h77);
    add(0, 0, 0, 0, 0);

    // Reset held, then released; the first two edges after release ignore accesses.
    repeat (3) @(negedge clk);
    chk("reset_rdvalid", 32'(readdatavalid), 32'd0);
    chk("reset_rdata", readdata, 32'd0);
    chk_irq("reset_irq", 1'b0);
    @(negedge clk);
    rst_in = 1'b1; address = 8'd1; write = 1'b1; writedata = 32'hAA; read = 1'b1;
    @(posedge clk); #1;
    chk("release_edge1_rdvalid", 32'(readdatavalid), 32'd0);
    @(negedge clk);
    address = 8'd5; writedata = 32'hBB;
    @(posedge clk); #1;
    chk("release_edge2_rdvalid", 32'(readdatavalid), 32'd0);
    write = 1'b0; read = 1'b0;
    m_reset();
    cycle(0, 0, 0, 1);
    chk("release_ctrl0_valid", 32'(readdatavalid), 32'd1);
    chk("release_ctrl0", readdata, 32'd0);
    cycle(1, 0, 0, 1);
    chk("ignored_load0", readdata, 32'd0);
    cycle(5, 0, 0, 1);
    chk("ignored_load1", readdata, 32'd0);

    foreach (tbl[i]) begin
      cycle(tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].rd);
      chk($sformatf("tbl%0d_rdvalid", i), 32'(readdatavalid), 32'(tbl[i].rd));
      if (tbl[i].rd) chk($sformatf("tbl%0d_rdata", i), readdata, tbl[i].exp);
    end

    // W1C on the exact expiry cycle keeps EXP set.
    cycle(6, 1, 2, 0); cycle(4, 1, 1, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    cycle(7, 1, 1, 0);
    cycle(7, 0, 0, 1); chk("w1c_on_expiry", readdata, 32'd1);
    cycle(4, 0, 0, 1); chk("oneshot_en_clear", readdata, 32'd0);
    cycle(7, 1, 1, 0);
    cycle(7, 0, 0, 1); chk("w1c_clears", readdata, 32'd0);

    // CTRL write on the one-shot auto-clear cycle takes the written value.
    cycle(6, 1, 1, 0); cycle(4, 1, 1, 0); cycle(0, 0, 0, 0);
    cycle(4, 1, 5, 0);
    cycle(4, 0, 0, 1); chk("ctrl_write_wins", readdata, 32'd5);
    cycle(4, 0, 0, 1); chk("ctrl_after_reexpire", readdata, 32'd4);
    cycle(4, 1, 0, 0); cycle(7, 1, 1, 0);

    // COUNT write on a tick cycle wins over the decrement.
    cycle(13, 1, 7, 0); cycle(14, 1, 10, 0); cycle(12, 1, 3, 0); cycle(0, 0, 0, 0);
    cycle(14, 1, 32'h20, 0);
    cycle(14, 0, 0, 1); chk("count_write_wins", readdata, 32'h20);
    cycle(14, 0, 0, 1); chk("count_after_write", readdata, 32'h1F);
    cycle(12, 1, 0, 0);

    // irq: channels 0 and 1 expire with IE set, then cleared one by one.
    cycle(6, 1, 2, 0); cycle(4, 1, 5, 0); cycle(0, 1, 5, 0);
    chk_irq("irq_low_before", 1'b0);
    cycle(0, 0, 0, 0); chk_irq("irq_low_exp_edge", 1'b0);
    cycle(0, 0, 0, 0); chk_irq("irq_rise", 1'b1);
    cycle(0, 0, 0, 0); chk_irq("irq_held", 1'b1);
    cycle(3, 1, 1, 0); chk_irq("irq_after_clr0", 1'b1);
    cycle(7, 1, 1, 0); chk_irq("irq_clr1_edge", 1'b1);
    cycle(0, 0, 0, 0); chk_irq("irq_fall", 1'b0);
    // Same with IE=0: irq never rises.
    cycle(6, 1, 2, 0); cycle(4, 1, 1, 0); cycle(0, 1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 0); chk_irq($sformatf("irq_masked%0d", k), 1'b0);
    end
    cycle(3, 0, 0, 1); chk("masked_exp0", readdata, 32'd1);
    cycle(3, 1, 1, 0); cycle(7, 1, 1, 0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int a;
      bit wr;
      bit rd;
      logic [31:0] wd;
      a  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(N_ADDR, 255))
                                         : int'($urandom_range(0, N_ADDR - 1));
      wr = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 1) == 1);
      if (a % 4 == 0) wd = $urandom_range(0, 7);
      else if ($urandom_range(0, 7) == 0) wd = $urandom;
      else wd = $urandom_range(0, 12);
      cycle(a, wr, wd, rd);
    end

    // Reset mid-count drops a pending readdatavalid at once.
    cycle(10, 1, 5, 0); cycle(8, 1, 3, 0);
    @(negedge clk);
    address = 8'd10; read = 1'b1;
    @(posedge clk); #2;
    read = 1'b0;
    chk("pre_reset_rdvalid", 32'(readdatavalid), 32'd1);
    rst_in = 1'b0;
    #1;
    chk("async_reset_rdvalid", 32'(readdatavalid), 32'd0);
    chk("async_reset_rdata", readdata, 32'd0);
    chk_irq("async_reset_irq", 1'b0);
    m_reset();
    @(negedge clk);
    rst_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cycle(10, 0, 0, 1); chk("count2_after_reset", readdata, 32'd0);
    cycle(8, 0, 0, 1);  chk("ctrl2_after_reset", readdata, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
